wb_sequencer: RTL and testbench
===============================

WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 SHALL have parameter SP_INIT, default 8'hFF, the stack-pointer value held after reset; it matches the R3 reset value in the register file.
REQ-002 SHALL have port clk, input, 1 bit: clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: a writeback request is present.
REQ-005 SHALL have port in_ready, output, 1 bit: the sequencer can accept a request this cycle.
REQ-006 SHALL have port in_op, input, 2 bits: 00 WR (rd<-data), 01 DEC (SP<-SP-1), 10 POP (rd<-data, then SP<-SP+1), 11 INC (SP<-SP+1).
REQ-007 SHALL have port in_rd, input, 2 bits: destination register.
REQ-008 SHALL have port in_data, input, 8 bits: write data.
REQ-009 SHALL have port rf_wr_en, output, 1 bit: drives the register-file write enable.
REQ-010 SHALL have port rf_addr, output, 2 bits: drives the register-file write address.
REQ-011 SHALL have port rf_data, output, 8 bits: drives the register-file write data.
REQ-012 SHALL have port sp_cur, output, 8 bits: shadow stack pointer, always equal to the committed R3.
REQ-013 SHALL have port stack_err, output, 1 bit: sticky stack wrap error (see Configuration).

Function
REQ-014 SHALL accept a request on the rising clk edge where in_valid=1 and in_ready=1.
REQ-015 SHALL have two states, IDLE and SECOND; in_ready SHALL be 1 in IDLE and 0 in SECOND.
REQ-016 SHALL register rf_wr_en, rf_addr and rf_data, giving one cycle of latency from accept to the write being presented.
REQ-017 SHALL deassert rf_wr_en in any cycle following an edge with no accept and no SECOND issue.
REQ-018 On WR, SHALL issue rf_addr=in_rd and rf_data=in_data; if in_rd=3, sp_cur SHALL also update to in_data.
REQ-019 On DEC or INC, SHALL issue rf_addr=3 and rf_data=sp_cur-1 or sp_cur+1 respectively, modulo 256, and SHALL update sp_cur to that value.
REQ-020 On POP with in_rd!=3, SHALL issue the rd write, go to SECOND, and on the next edge issue rf_addr=3 with rf_data=sp_cur+1 (modulo 256), update sp_cur, and return to IDLE.
REQ-021 On POP with in_rd=3, SHALL issue only the rd write (data wins), set sp_cur to in_data, and stay in IDLE.
REQ-022 SHALL derive every SP computation from sp_cur and never from register-file read data, so back-to-back stack ops need no stall.
REQ-023 SHALL ignore in_valid while in SECOND; upstream SHALL hold its request until in_ready=1.
REQ-024 Wrap-around: DEC at sp_cur=8'h00 SHALL give 8'hFF; INC or POP at sp_cur=8'hFF SHALL give 8'h00.

Reset
REQ-025 On rst=0, SHALL immediately force state=IDLE, rf_wr_en=0, rf_addr=0, rf_data=0, sp_cur=SP_INIT and stack_err=0, regardless of clk.
REQ-026 A reset asserted while in SECOND SHALL abandon the pending SP write; no write SHALL occur after reset is released until a new accept.
REQ-027 in_ready SHALL be 1 on the first cycle after reset is released.

Configuration
REQ-028 The macro WB_STACK_CHECK_EN, when defined, SHALL cause stack_err to set on any SP wrap per REQ-024 and to hold until reset; the SP write SHALL still occur.
REQ-029 When WB_STACK_CHECK_EN is undefined, stack_err SHALL be constant 0 and no wrap-detect logic SHALL be present.

Verification
REQ-030 Reset, then WR rd=1 data=8'h5A -> next cycle rf_wr_en=1, rf_addr=1, rf_data=8'h5A; sp_cur=8'hFF.
REQ-031 DEC, DEC, INC issued back-to-back from reset -> rf_data sequence 8'hFE, 8'hFD, 8'hFE on addr 3, in_ready held at 1.
REQ-032 POP rd=2 data=8'h33 at sp_cur=8'hFD -> cycle 1 addr 2 / 8'h33, in_ready=0; cycle 2 addr 3 / 8'hFE; in_ready=1 after.
REQ-033 POP rd=3 data=8'h80 -> single write addr 3 / 8'h80, sp_cur=8'h80, no SECOND cycle.
REQ-034 With WB_STACK_CHECK_EN: INC at sp_cur=8'hFF -> rf_data=8'h00 and stack_err=1, held until rst=0; without the macro, stack_err stays 0.
REQ-035 Assert rst mid-SECOND of a POP -> rf_wr_en=0 immediately, sp_cur=8'hFF, and no addr-3 write after release.

Source files
------------

// File: rtl/wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wb_sequencer
// Purpose  : Writeback sequencer in front of a 4-entry register file whose
//            R3 is the stack pointer. Issues one registered write per cycle.
//            DEC/INC update SP directly. POP with rd!=3 takes two cycles:
//            the rd write first, then the SP+1 write. SP arithmetic always
//            uses the shadow copy (sp_cur), so stack ops never stall.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SP_INIT   : stack-pointer value after reset (same as R3 reset value)
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active low
//   in_valid  : writeback request present
//   in_ready  : request can be accepted this cycle (low in SECOND)
//   in_op     : 00 WR, 01 DEC, 10 POP, 11 INC
//   in_rd     : destination register
//   in_data   : write data
//   rf_wr_en  : register-file write enable (registered)
//   rf_addr   : register-file write address (registered)
//   rf_data   : register-file write data (registered)
//   sp_cur    : shadow stack pointer, tracks committed R3
//   stack_err : sticky SP wrap error
// Build option
//   WB_STACK_CHECK_EN : when defined, stack_err sets on any SP wrap and holds
//                       until reset; when undefined, stack_err is tied to 0.
// ============================================================================
module wb_sequencer #(
  parameter logic [7:0] SP_INIT = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_op,
  input  logic [1:0] in_rd,
  input  logic [7:0] in_data,
  output logic       rf_wr_en,
  output logic [1:0] rf_addr,
  output logic [7:0] rf_data,
  output logic [7:0] sp_cur,
  output logic       stack_err
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_SECOND = 1'b1
  } state_t;

  localparam logic [1:0] c_OP_WR  = 2'b00;
  localparam logic [1:0] c_OP_DEC = 2'b01;
  localparam logic [1:0] c_OP_POP = 2'b10;
  localparam logic [1:0] c_OP_INC = 2'b11;
  localparam logic [1:0] c_SP_REG = 2'd3;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_wr_en;
  logic [1:0] r_addr;
  logic [7:0] r_data;
  logic [7:0] r_sp;

  logic       w_accept;
  logic       w_wr_en_nxt;
  logic [1:0] w_addr_nxt;
  logic [7:0] w_data_nxt;
  logic [7:0] w_sp_nxt;
  logic [7:0] w_sp_inc;
  logic [7:0] w_sp_dec;

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid && in_ready;
  assign w_sp_inc = r_sp + 8'd1;
  assign w_sp_dec = r_sp - 8'd1;

  // State and write-port registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_wr_en <= 1'b0;
      r_addr  <= 2'd0;
      r_data  <= 8'd0;
      r_sp    <= SP_INIT;
    end else begin
      r_state <= w_state_nxt;
      r_wr_en <= w_wr_en_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_sp    <= w_sp_nxt;
    end
  end

  // Next-state and next-write decode
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en_nxt = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_sp_nxt    = r_sp;
    if (r_state == S_SECOND) begin
      // Deferred SP increment of a POP; in_valid is ignored here.
      w_wr_en_nxt = 1'b1;
      w_addr_nxt  = c_SP_REG;
      w_data_nxt  = w_sp_inc;
      w_sp_nxt    = w_sp_inc;
      w_state_nxt = S_IDLE;
    end else if (w_accept) begin
      w_wr_en_nxt = 1'b1;
      unique case (in_op)
        c_OP_WR: begin
          w_addr_nxt = in_rd;
          w_data_nxt = in_data;
          if (in_rd == c_SP_REG) w_sp_nxt = in_data;
        end
        c_OP_DEC: begin
          w_addr_nxt = c_SP_REG;
          w_data_nxt = w_sp_dec;
          w_sp_nxt   = w_sp_dec;
        end
        c_OP_POP: begin
          w_addr_nxt = in_rd;
          w_data_nxt = in_data;
          // Popping into R3 itself: the popped data wins, no SP increment.
          if (in_rd == c_SP_REG) w_sp_nxt = in_data;
          else                   w_state_nxt = S_SECOND;
        end
        c_OP_INC: begin
          w_addr_nxt = c_SP_REG;
          w_data_nxt = w_sp_inc;
          w_sp_nxt   = w_sp_inc;
        end
        default: begin
          w_wr_en_nxt = 1'b0;
        end
      endcase
    end
  end

  assign rf_wr_en = r_wr_en;
  assign rf_addr  = r_addr;
  assign rf_data  = r_data;
  assign sp_cur   = r_sp;

`ifdef WB_STACK_CHECK_EN
  logic r_err;
  logic w_wrap;

  // A wrap is any SP step that crosses the 00/FF boundary.
  always_comb begin
    w_wrap = 1'b0;
    if (r_state == S_SECOND) begin
      w_wrap = (r_sp == 8'hFF);
    end else if (w_accept) begin
      unique case (in_op)
        c_OP_DEC: w_wrap = (r_sp == 8'h00);
        c_OP_INC: w_wrap = (r_sp == 8'hFF);
        default:  w_wrap = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_err <= 1'b0;
    else if (w_wrap) r_err <= 1'b1;
  end

  assign stack_err = r_err;
`else
  assign stack_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_sequencer
// Purpose  : Self-checking bench for wb_sequencer. Directed scenarios plus a
//            randomized run, all checked against a behavioural model that
//            tracks SP as an integer and the pending POP increment as a flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_sequencer;

`ifdef WB_STACK_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [1:0] in_rd;
  logic [7:0] in_data;
  logic       rf_wr_en;
  logic [1:0] rf_addr;
  logic [7:0] rf_data;
  logic [7:0] sp_cur;
  logic       stack_err;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state and expected outputs
  int         m_sp;
  bit         m_pend;
  bit         m_err;
  bit         e_wr;
  logic [1:0] e_addr;
  logic [7:0] e_data;

  wb_sequencer #(.SP_INIT(8'hFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .rf_wr_en  (rf_wr_en),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .sp_cur    (sp_cur),
    .stack_err (stack_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model_reset();
    m_sp   = 255;
    m_pend = 1'b0;
    m_err  = 1'b0;
    e_wr   = 1'b0;
    e_addr = 2'd0;
    e_data = 8'd0;
  endfunction

  // One clock of the specified behaviour, given the inputs presented.
  function automatic void model_step(bit v, logic [1:0] op, logic [1:0] rd, logic [7:0] d);
    int nsp;
    bit wrapped;
    wrapped = 1'b0;
    e_wr    = 1'b0;
    if (m_pend) begin
      nsp = m_sp + 1;
      wrapped = (nsp > 255);
      m_sp = nsp % 256;
      e_wr = 1'b1; e_addr = 2'd3; e_data = 8'(m_sp);
      m_pend = 1'b0;
    end else if (v) begin
      e_wr = 1'b1;
      case (op)
        2'b00, 2'b10: begin
          e_addr = rd; e_data = d;
          if (rd == 2'd3) m_sp = int'(d);
          else if (op == 2'b10) m_pend = 1'b1;
        end
        2'b01: begin
          nsp = m_sp - 1;
          wrapped = (nsp < 0);
          m_sp = (nsp + 256) % 256;
          e_addr = 2'd3; e_data = 8'(m_sp);
        end
        default: begin
          nsp = m_sp + 1;
          wrapped = (nsp > 255);
          m_sp = nsp % 256;
          e_addr = 2'd3; e_data = 8'(m_sp);
        end
      endcase
    end
    if (CHK && wrapped) m_err = 1'b1;
  endfunction

  task automatic cycle(input bit v, input logic [1:0] op, input logic [1:0] rd, input logic [7:0] d);
    in_valid = v; in_op = op; in_rd = rd; in_data = d;
    model_step(v, op, rd, d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; in_op = 2'b00; in_rd = 2'd0; in_data = 8'd0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    n_vec++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b want 0", rf_wr_en); end
    n_vec++; if (rf_addr !== 2'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", rf_addr); end
    n_vec++; if (rf_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", rf_data); end
    n_vec++; if (sp_cur !== 8'hFF) begin n_err++; $display("FAIL reset_sp: got %h want FF", sp_cur); end
    n_vec++; if (stack_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", stack_err); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_wr();
    do_reset();
    cycle(1'b1, 2'b00, 2'd1, 8'h5A);
    n_vec++; if ({rf_wr_en, rf_addr, rf_data} !== {1'b1, 2'd1, 8'h5A})
      begin n_err++; $display("FAIL wr_issue: got en=%b a=%0d d=%h want en=1 a=1 d=5A", rf_wr_en, rf_addr, rf_data); end
    n_vec++; if (sp_cur !== 8'hFF) begin n_err++; $display("FAIL wr_sp: got %h want FF", sp_cur); end
    cycle(1'b0, 2'b00, 2'd0, 8'h00);
    n_vec++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL wr_idle_en: got %b want 0", rf_wr_en); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [3];
    logic [1:0] ops  [3];
    want = '{8'hFE, 8'hFD, 8'hFE};
    ops  = '{2'b01, 2'b01, 2'b11};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, ops[i], 2'd0, 8'h00);
      n_vec++; if ({rf_wr_en, rf_addr, rf_data} !== {1'b1, 2'd3, want[i]})
        begin n_err++; $display("FAIL b2b_%0d: got en=%b a=%0d d=%h want en=1 a=3 d=%h", i, rf_wr_en, rf_addr, rf_data, want[i]); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_%0d: got %b want 1", i, in_ready); end
    end
  endtask

  task automatic test_pop();
    // Continues from SP=FE left by test_back_to_back; DEC takes it to FD.
    cycle(1'b1, 2'b01, 2'd0, 8'h00);
    n_vec++; if (sp_cur !== 8'hFD) begin n_err++; $display("FAIL pop_pre_sp: got %h want FD", sp_cur); end
    cycle(1'b1, 2'b10, 2'd2, 8'h33);
    n_vec++; if ({rf_wr_en, rf_addr, rf_data} !== {1'b1, 2'd2, 8'h33})
      begin n_err++; $display("FAIL pop_first: got en=%b a=%0d d=%h want en=1 a=2 d=33", rf_wr_en, rf_addr, rf_data); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL pop_busy: got %b want 0", in_ready); end
    // A new request presented during SECOND must be held off, not taken.
    cycle(1'b1, 2'b00, 2'd0, 8'hAA);
    n_vec++; if ({rf_wr_en, rf_addr, rf_data} !== {1'b1, 2'd3, 8'hFE})
      begin n_err++; $display("FAIL pop_second: got en=%b a=%0d d=%h want en=1 a=3 d=FE", rf_wr_en, rf_addr, rf_data); end
    n_vec++; if (sp_cur !== 8'hFE) begin n_err++; $display("FAIL pop_sp: got %h want FE", sp_cur); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL pop_ready: got %b want 1", in_ready); end
    cycle(1'b1, 2'b00, 2'd0, 8'hAA);
    n_vec++; if ({rf_wr_en, rf_addr, rf_data} !== {1'b1, 2'd0, 8'hAA})
      begin n_err++; $display("FAIL pop_held_req: got en=%b a=%0d d=%h want en=1 a=0 d=AA", rf_wr_en, rf_addr, rf_data); end
  endtask

  task automatic test_pop_rd3();
    cycle(1'b1, 2'b10, 2'd3, 8'h80);
    n_vec++; if ({rf_wr_en, rf_addr, rf_data} !== {1'b1, 2'd3, 8'h80})
      begin n_err++; $display("FAIL pop3_issue: got en=%b a=%0d d=%h want en=1 a=3 d=80", rf_wr_en, rf_addr, rf_data); end
    n_vec++; if (sp_cur !== 8'h80) begin n_err++; $display("FAIL pop3_sp: got %h want 80", sp_cur); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL pop3_ready: got %b want 1", in_ready); end
    cycle(1'b0, 2'b00, 2'd0, 8'h00);
    n_vec++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL pop3_no_second: got %b want 0", rf_wr_en); end
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(1'b1, 2'b11, 2'd0, 8'h00);
    n_vec++; if ({rf_addr, rf_data} !== {2'd3, 8'h00})
      begin n_err++; $display("FAIL wrap_inc: got a=%0d d=%h want a=3 d=00", rf_addr, rf_data); end
    n_vec++; if (stack_err !== CHK) begin n_err++; $display("FAIL wrap_inc_err: got %b want %b", stack_err, CHK); end
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'b00, 2'd0, 8'h00);
    n_vec++; if (stack_err !== CHK) begin n_err++; $display("FAIL wrap_hold: got %b want %b", stack_err, CHK); end
    do_reset();
    n_vec++; if (stack_err !== 1'b0) begin n_err++; $display("FAIL wrap_clear: got %b want 0", stack_err); end
    cycle(1'b1, 2'b00, 2'd3, 8'h00);
    n_vec++; if (stack_err !== 1'b0) begin n_err++; $display("FAIL wrap_no_false: got %b want 0", stack_err); end
    cycle(1'b1, 2'b01, 2'd0, 8'h00);
    n_vec++; if ({rf_data, sp_cur} !== {8'hFF, 8'hFF})
      begin n_err++; $display("FAIL wrap_dec: got d=%h sp=%h want d=FF sp=FF", rf_data, sp_cur); end
    n_vec++; if (stack_err !== CHK) begin n_err++; $display("FAIL wrap_dec_err: got %b want %b", stack_err, CHK); end
    // POP second-cycle increment from FF also wraps.
    do_reset();
    cycle(1'b1, 2'b10, 2'd0, 8'h11);
    cycle(1'b0, 2'b00, 2'd0, 8'h00);
    n_vec++; if ({rf_addr, rf_data, sp_cur} !== {2'd3, 8'h00, 8'h00})
      begin n_err++; $display("FAIL wrap_pop: got a=%0d d=%h sp=%h want a=3 d=00 sp=00", rf_addr, rf_data, sp_cur); end
    n_vec++; if (stack_err !== CHK) begin n_err++; $display("FAIL wrap_pop_err: got %b want %b", stack_err, CHK); end
  endtask

  task automatic test_reset_mid_second();
    do_reset();
    cycle(1'b1, 2'b01, 2'd0, 8'h00);
    cycle(1'b1, 2'b10, 2'd1, 8'h44);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_vec++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL rst2_en: got %b want 0", rf_wr_en); end
    n_vec++; if (sp_cur !== 8'hFF) begin n_err++; $display("FAIL rst2_sp: got %h want FF", sp_cur); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 2'b00, 2'd0, 8'h00);
      n_vec++; if ({rf_wr_en, in_ready, sp_cur} !== {1'b0, 1'b1, 8'hFF})
        begin n_err++; $display("FAIL rst2_after_%0d: got en=%b rdy=%b sp=%h want en=0 rdy=1 sp=FF", i, rf_wr_en, in_ready, sp_cur); end
    end
  endtask

  task automatic test_random();
    bit         v;
    logic [1:0] op;
    logic [1:0] rd;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      // Upstream holds its request while the sequencer is busy.
      if (in_ready || !in_valid) begin
        v  = ($urandom_range(0, 3) != 0);
        op = 2'($urandom_range(0, 3));
        rd = 2'($urandom_range(0, 3));
        d  = 8'($urandom_range(0, 255));
        // Steer SP toward the wrap boundaries now and then.
        if ($urandom_range(0, 15) == 0) begin op = 2'b00; rd = 2'd3; d = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00; end
      end
      cycle(v, op, rd, d);
      n_vec++;
      if (rf_wr_en !== e_wr || (e_wr && (rf_addr !== e_addr || rf_data !== e_data)) ||
          sp_cur !== 8'(m_sp) || in_ready !== !m_pend || stack_err !== m_err) begin
        n_err++;
        $display("FAIL rand_%0d: got en=%b a=%0d d=%h sp=%h rdy=%b err=%b want en=%b a=%0d d=%h sp=%h rdy=%b err=%b",
                 i, rf_wr_en, rf_addr, rf_data, sp_cur, in_ready, stack_err,
                 e_wr, e_addr, e_data, 8'(m_sp), !m_pend, m_err);
      end
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_rd = 2'd0; in_data = 8'd0;
    model_reset();
    test_reset();
    test_wr();
    test_back_to_back();
    test_pop();
    test_pop_rd3();
    test_wrap();
    test_reset_mid_second();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
